sevenseg_display_sched: RTL and testbench

Scheduler that shares the single hex seven-segment digit between two requesters: the trainer status logic (A) and the user-entry logic (B). It arbitrates between them round-robin, latches the winner's 4-bit value, and holds it on the display for a fixed number of half-periods. It also generates the blink phase that drives the digit decoder's `value` and `timeout_1s` inputs, so the decoder blanks the digit while the phase is high.

---
 rtl/sevenseg_display_sched_if.sv | 46 ++++
 rtl/sevenseg_display_sched.sv | 135 +++++++++++++
 tb/tb_sevenseg_display_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/sevenseg_display_sched_if.sv
// Request/grant and display bundle between the two digit requesters
// and the seven-segment display scheduler.
interface sevenseg_display_sched_if;
  logic       req_a;
  logic [3:0] val_a;
  logic       blink_a;
  logic       req_b;
  logic [3:0] val_b;
  logic       blink_b;
  logic       gnt_a;
  logic       gnt_b;
  logic [3:0] value;
  logic       timeout_1s;
  logic [1:0] owner;
  logic       busy;

  modport master (
    output req_a,
    output val_a,
    output blink_a,
    output req_b,
    output val_b,
    output blink_b,
    input  gnt_a,
    input  gnt_b,
    input  value,
    input  timeout_1s,
    input  owner,
    input  busy
  );

  modport slave (
    input  req_a,
    input  val_a,
    input  blink_a,
    input  req_b,
    input  val_b,
    input  blink_b,
    output gnt_a,
    output gnt_b,
    output value,
    output timeout_1s,
    output owner,
    output busy
  );
endinterface

// File: rtl/sevenseg_display_sched.sv
// Round-robin owner of the single hex digit: latches the winner's
// value, holds it for a fixed number of blink half-periods.
module sevenseg_display_sched #(
  parameter int HALF_PERIOD = 25_000_000,
  parameter int HOLD_HALVES = 4,
  parameter int CW          = 25
) (
  input  logic clk,
  input  logic rst,
  sevenseg_display_sched_if.slave bus
);

  localparam int HW = $clog2(HOLD_HALVES + 1);
  localparam logic [CW-1:0] PC_LAST = CW'(HALF_PERIOD - 1);
  localparam logic [HW-1:0] HV_LAST = HW'(HOLD_HALVES - 1);

  typedef enum logic [1:0] {
    IDLE,
    SHOW_A,
    SHOW_B
  } state_t;

  state_t        state;
  state_t        state_n;
  logic          last_b;
  logic          last_b_n;
  logic [CW-1:0] pcnt;
  logic [CW-1:0] pcnt_n;
  logic [HW-1:0] halves;
  logic [HW-1:0] halves_n;
  logic          phase;
  logic          phase_n;
  logic          blink_l;
  logic          blink_l_n;
  logic [3:0]    value_q;
  logic [3:0]    value_n;
  logic          gnt_a_q;
  logic          gnt_a_n;
  logic          gnt_b_q;
  logic          gnt_b_n;
  logic          pick_a;
  logic          pick_b;

  // On contention the requester that did not win last time goes first.
  assign pick_a = bus.req_a & (~bus.req_b | last_b);
  assign pick_b = bus.req_b & (~bus.req_a | ~last_b);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      last_b  <= 1'b1;
      pcnt    <= '0;
      halves  <= '0;
      phase   <= 1'b0;
      blink_l <= 1'b0;
      value_q <= 4'h0;
      gnt_a_q <= 1'b0;
      gnt_b_q <= 1'b0;
    end else begin
      state   <= state_n;
      last_b  <= last_b_n;
      pcnt    <= pcnt_n;
      halves  <= halves_n;
      phase   <= phase_n;
      blink_l <= blink_l_n;
      value_q <= value_n;
      gnt_a_q <= gnt_a_n;
      gnt_b_q <= gnt_b_n;
    end
  end

  always_comb begin
    state_n   = state;
    last_b_n  = last_b;
    pcnt_n    = pcnt;
    halves_n  = halves;
    phase_n   = phase;
    blink_l_n = blink_l;
    value_n   = value_q;
    gnt_a_n   = 1'b0;
    gnt_b_n   = 1'b0;
    unique case (state)
      IDLE: begin
        unique case (1'b1)
          pick_a: begin
            state_n   = SHOW_A;
            value_n   = bus.val_a;
            blink_l_n = bus.blink_a;
            pcnt_n    = '0;
            halves_n  = '0;
            phase_n   = 1'b0;
            last_b_n  = 1'b0;
            gnt_a_n   = 1'b1;
          end
          pick_b: begin
            state_n   = SHOW_B;
            value_n   = bus.val_b;
            blink_l_n = bus.blink_b;
            pcnt_n    = '0;
            halves_n  = '0;
            phase_n   = 1'b0;
            last_b_n  = 1'b1;
            gnt_b_n   = 1'b1;
          end
          default: ;
        endcase
      end
      SHOW_A, SHOW_B: begin
        if (pcnt == PC_LAST) begin
          pcnt_n = '0;
          if (halves == HV_LAST) begin
            state_n  = IDLE;
            phase_n  = 1'b0;
            halves_n = '0;
          end else begin
            phase_n  = ~phase;
            halves_n = halves + 1'b1;
          end
        end else begin
          pcnt_n = pcnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // phase is forced low outside a window, so this is already 0 in IDLE.
  assign bus.timeout_1s = blink_l & phase;
  assign bus.value      = value_q;
  assign bus.gnt_a      = gnt_a_q;
  assign bus.gnt_b      = gnt_b_q;
  assign bus.owner      = {state == SHOW_B, state == SHOW_A};
  assign bus.busy       = (state != IDLE);

endmodule

// File: tb/tb_sevenseg_display_sched.sv
// Directed bench for the display scheduler with a 4-cycle half-period
// and a 4-half hold, i.e. 16-cycle windows.
module tb_sevenseg_display_sched;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  sevenseg_display_sched_if bus ();

  sevenseg_display_sched #(
    .HALF_PERIOD(4),
    .HOLD_HALVES(4),
    .CW(3)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs,
                     input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_idle;
    int n;
    n = 0;
    while (bus.busy !== 1'b0 && n < 40) begin
      step;
      n++;
    end
    chk("idle_bound", {7'd0, bus.busy}, 8'd0);
  endtask

  logic [15:0] pat;
  int          g_cyc[$];
  logic        g_who[$];
  logic        prev_g;
  int          dbl;
  int          a_seen;

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b0;
    bus.req_a = 0; bus.val_a = 0; bus.blink_a = 0;
    bus.req_b = 0; bus.val_b = 0; bus.blink_b = 0;
    step;
    step;
    rst = 1'b1;
    chk("rst_value", {4'd0, bus.value}, 8'h00);
    chk("rst_gnt", {6'd0, bus.gnt_a, bus.gnt_b}, 8'h00);
    chk("rst_owner", {6'd0, bus.owner}, 8'h00);
    chk("rst_busy", {7'd0, bus.busy}, 8'h00);
    chk("rst_tmo", {7'd0, bus.timeout_1s}, 8'h00);

    // A alone, no blink
    bus.req_a = 1; bus.val_a = 4'h7; bus.blink_a = 0;
    step;
    chk("a_gnt", {7'd0, bus.gnt_a}, 8'h01);
    chk("a_value", {4'd0, bus.value}, 8'h07);
    chk("a_owner", {6'd0, bus.owner}, 8'h01);
    chk("a_busy", {7'd0, bus.busy}, 8'h01);
    chk("a_tmo0", {7'd0, bus.timeout_1s}, 8'h00);
    bus.req_a = 0;
    for (int i = 2; i <= 16; i++) begin
      step;
      chk("a_win", {4'd0, bus.gnt_a, bus.busy, bus.timeout_1s,
                    bus.owner[0], bus.value}, 8'h57);
    end
    step;
    chk("a_end_busy", {7'd0, bus.busy}, 8'h00);
    chk("a_end_owner", {6'd0, bus.owner}, 8'h00);
    chk("a_end_value", {4'd0, bus.value}, 8'h07);

    // B alone, blinking
    pat = 16'b1111_0000_1111_0000;
    bus.req_b = 1; bus.val_b = 4'hC; bus.blink_b = 1;
    step;
    chk("b_gnt", {7'd0, bus.gnt_b}, 8'h01);
    chk("b_owner", {6'd0, bus.owner}, 8'h02);
    chk("b_value", {4'd0, bus.value}, 8'h0C);
    bus.req_b = 0;
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("b_tmo%0d", i), {7'd0, bus.timeout_1s},
          {7'd0, pat[i]});
      step;
    end
    chk("b_idle_tmo", {7'd0, bus.timeout_1s}, 8'h00);
    chk("b_idle_busy", {7'd0, bus.busy}, 8'h00);

    // both held: A, B, A, B... 17 cycles apart
    bus.req_a = 1; bus.val_a = 4'h1; bus.blink_a = 0;
    bus.req_b = 1; bus.val_b = 4'h2; bus.blink_b = 0;
    prev_g = 0;
    dbl = 0;
    for (int s = 1; s <= 80; s++) begin
      step;
      if (prev_g && (bus.gnt_a || bus.gnt_b)) dbl++;
      prev_g = bus.gnt_a | bus.gnt_b;
      if (bus.gnt_a || bus.gnt_b) begin
        g_cyc.push_back(s);
        g_who.push_back(bus.gnt_b);
        chk("rr_onehot", {6'd0, bus.gnt_a, bus.gnt_b},
            bus.gnt_b ? 8'h01 : 8'h02);
      end
    end
    bus.req_a = 0; bus.req_b = 0;
    chk("rr_count", 8'(g_cyc.size()), 8'd5);
    chk("rr_double", 8'(dbl), 8'd0);
    chk("rr_first", 8'(g_cyc.size() > 0 ? g_cyc[0] : 0), 8'd1);
    if (g_cyc.size() >= 4) begin
      for (int i = 0; i < 4; i++)
        chk($sformatf("rr_who%0d", i), {7'd0, g_who[i]}, 8'(i % 2));
      for (int i = 1; i < 4; i++)
        chk($sformatf("rr_gap%0d", i), 8'(g_cyc[i] - g_cyc[i-1]),
            8'd17);
    end
    wait_idle;

    // B arrives mid A window and waits
    bus.req_a = 1; bus.val_a = 4'h3;
    step;
    chk("m_gnt_a", {7'd0, bus.gnt_a}, 8'h01);
    bus.req_a = 0;
    for (int s = 2; s <= 16; s++) begin
      step;
      chk("m_wait", {3'd0, bus.gnt_b, bus.value}, 8'h03);
      if (s == 8) begin
        bus.req_b = 1; bus.val_b = 4'h9; bus.blink_b = 0;
      end
    end
    step;
    chk("m_idle", {6'd0, bus.gnt_b, bus.busy}, 8'h00);
    step;
    chk("m_gnt_b", {7'd0, bus.gnt_b}, 8'h01);
    chk("m_value_b", {4'd0, bus.value}, 8'h09);
    bus.req_b = 0;
    wait_idle;

    // reset inside a blinking window
    bus.req_a = 1; bus.val_a = 4'h5; bus.blink_a = 1;
    step;
    chk("r_gnt_a", {7'd0, bus.gnt_a}, 8'h01);
    bus.req_a = 0;
    for (int i = 0; i < 5; i++) step;
    chk("r_tmo6", {7'd0, bus.timeout_1s}, 8'h01);
    rst = 1'b0;
    step;
    chk("r_value", {4'd0, bus.value}, 8'h00);
    chk("r_outs", {3'd0, bus.gnt_a, bus.gnt_b, bus.owner[1],
                   bus.owner[0], bus.busy}, 8'h00);
    chk("r_tmo", {7'd0, bus.timeout_1s}, 8'h00);
    rst = 1'b1;
    bus.req_a = 1; bus.val_a = 4'hA; bus.blink_a = 0;
    bus.req_b = 1; bus.val_b = 4'hB; bus.blink_b = 0;
    step;
    chk("r_first", {6'd0, bus.gnt_a, bus.gnt_b}, 8'h02);
    chk("r_owner", {6'd0, bus.owner}, 8'h01);
    bus.req_a = 0; bus.req_b = 0;
    wait_idle;

    // short A pulse during B window is dropped
    bus.req_b = 1; bus.val_b = 4'hE;
    step;
    chk("p_gnt_b", {7'd0, bus.gnt_b}, 8'h01);
    bus.req_b = 0;
    step; step; step;
    bus.req_a = 1;
    step;
    bus.req_a = 0;
    a_seen = 0;
    for (int i = 0; i < 30; i++) begin
      step;
      if (bus.gnt_a || bus.owner == 2'b01) a_seen++;
    end
    chk("p_no_a", 8'(a_seen), 8'd0);
    chk("p_value", {4'd0, bus.value}, 8'h0E);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
